// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 DIT twiddle sequencer.
// Holds the FSM state encoding, parameter defaults and the 8-point Q1.15 twiddle table.
package fft_pkg;

  localparam int unsigned DataWDef = 16;
  localparam int unsigned Log2NDef = 3;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StCapt,
    StPresent
  } seq_state_e;

  // W8^k = exp(-j*2*pi*k/8) in Q1.15
  localparam logic [15:0] W8Re0 = 16'h7FFF;
  localparam logic [15:0] W8Im0 = 16'h0000;
  localparam logic [15:0] W8Re1 = 16'h5A82;
  localparam logic [15:0] W8Im1 = 16'hA57E;
  localparam logic [15:0] W8Re2 = 16'h0000;
  localparam logic [15:0] W8Im2 = 16'h8001;
  localparam logic [15:0] W8Re3 = 16'hA57E;
  localparam logic [15:0] W8Im3 = 16'hA57E;

  function automatic int unsigned stage_w(input int unsigned log2n);
    return (log2n > 1) ? $clog2(log2n) : 1;
  endfunction

  function automatic logic [15:0] twiddle8_re(input logic [1:0] k);
    logic [15:0] r;
    unique case (k)
      2'd0:    r = W8Re0;
      2'd1:    r = W8Re1;
      2'd2:    r = W8Re2;
      default: r = W8Re3;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] twiddle8_im(input logic [1:0] k);
    logic [15:0] r;
    unique case (k)
      2'd0:    r = W8Im0;
      2'd1:    r = W8Im1;
      2'd2:    r = W8Im2;
      default: r = W8Im3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bf_addr_gen.sv
// Combinational butterfly address generator: (stage, butterfly) -> top/bottom sample
// addresses and twiddle index for an in-place radix-2 DIT FFT.
module bf_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = Log2NDef,
  localparam int unsigned StageW = stage_w(LOG2N),
  localparam int unsigned BflyW = (LOG2N > 1) ? LOG2N - 1 : 1
) (
  input  logic [StageW-1:0] stage_i,
  input  logic [BflyW-1:0]  bfly_i,
  output logic [LOG2N-1:0]  top_o,
  output logic [LOG2N-1:0]  bot_o,
  output logic [LOG2N-1:0]  k_o
);

  logic [LOG2N-1:0] bfly_ext;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] pos;
  int unsigned      sh;

  always_comb begin
    sh       = 32'(stage_i);
    bfly_ext = LOG2N'(bfly_i);
    span     = LOG2N'(1) << sh;
    pos      = bfly_ext & (span - LOG2N'(1));
    // Group base is (b / span) * 2 * span; pos walks within the group.
    top_o    = ((bfly_ext >> sh) << (sh + 1)) + pos;
    bot_o    = top_o + span;
    k_o      = pos << (LOG2N - 1 - sh);
  end

endmodule

// File: rtl/twiddle_sequencer.sv
// Walks every butterfly of a radix-2 DIT FFT, fetches each twiddle from an external
// registered ROM and presents one descriptor per butterfly over valid/ready.
module twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned LOG2N = Log2NDef,
  localparam int unsigned StageW = stage_w(LOG2N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [LOG2N-1:0]  rom_index,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_wreal,
  input  logic [DATA_W-1:0] rom_wimag,
  output logic              bf_valid,
  input  logic              bf_ready,
  output logic [DATA_W-1:0] bf_wreal,
  output logic [DATA_W-1:0] bf_wimag,
  output logic [LOG2N-1:0]  bf_top,
  output logic [LOG2N-1:0]  bf_bot,
  output logic [StageW-1:0] bf_stage,
  output logic              bf_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BflyW = (LOG2N > 1) ? LOG2N - 1 : 1;
  localparam logic [BflyW-1:0]  BflyLast  = '1;
  localparam logic [StageW-1:0] StageLast = StageW'(LOG2N - 1);

  seq_state_e        state_q, state_d;
  logic [StageW-1:0] stage_q, stage_d;
  logic [BflyW-1:0]  bfly_q, bfly_d;

  logic              rom_en_q, rom_en_d;
  logic [LOG2N-1:0]  rom_index_q, rom_index_d;
  logic              bf_valid_q, bf_valid_d;
  logic [DATA_W-1:0] bf_wreal_q, bf_wreal_d;
  logic [DATA_W-1:0] bf_wimag_q, bf_wimag_d;
  logic [LOG2N-1:0]  bf_top_q, bf_top_d;
  logic [LOG2N-1:0]  bf_bot_q, bf_bot_d;
  logic [StageW-1:0] bf_stage_q, bf_stage_d;
  logic              bf_last_q, bf_last_d;
  logic              done_q, done_d;

  logic [LOG2N-1:0]  gen_top, gen_bot, gen_k;
  logic              handshake;

  assign handshake = bf_valid_q & bf_ready;

  // Driven from the next-state counters: in CAPT they equal the current butterfly, and on
  // the edge entering FETCH they already point at the butterfly about to be fetched.
  bf_addr_gen #(
    .LOG2N (LOG2N)
  ) u_addr_gen (
    .stage_i (stage_d),
    .bfly_i  (bfly_d),
    .top_o   (gen_top),
    .bot_o   (gen_bot),
    .k_o     (gen_k)
  );

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StFetch;
            stage_d = '0;
            bfly_d  = '0;
          end
        end
        StFetch: state_d = StCapt;
        StCapt:  state_d = StPresent;
        StPresent: begin
          if (handshake) begin
            if (bf_last_q) begin
              state_d = StIdle;
            end else begin
              state_d = StFetch;
              if (bfly_q == BflyLast) begin
                bfly_d  = '0;
                stage_d = stage_q + 1'b1;
              end else begin
                bfly_d = bfly_q + 1'b1;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    rom_en_d    = 1'b0;
    rom_index_d = rom_index_q;
    bf_valid_d  = bf_valid_q;
    bf_wreal_d  = bf_wreal_q;
    bf_wimag_d  = bf_wimag_q;
    bf_top_d    = bf_top_q;
    bf_bot_d    = bf_bot_q;
    bf_stage_d  = bf_stage_q;
    bf_last_d   = bf_last_q;
    done_d      = 1'b0;
    if (abort) begin
      bf_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            rom_en_d    = 1'b1;
            rom_index_d = gen_k;
          end
        end
        StCapt: begin
          bf_valid_d = 1'b1;
          bf_wreal_d = rom_wreal;
          bf_wimag_d = rom_wimag;
          bf_top_d   = gen_top;
          bf_bot_d   = gen_bot;
          bf_stage_d = stage_q;
          bf_last_d  = (stage_q == StageLast) && (bfly_q == BflyLast);
        end
        StPresent: begin
          if (handshake) begin
            bf_valid_d = 1'b0;
            if (bf_last_q) begin
              done_d = 1'b1;
            end else begin
              rom_en_d    = 1'b1;
              rom_index_d = gen_k;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      stage_q     <= '0;
      bfly_q      <= '0;
      rom_en_q    <= 1'b0;
      rom_index_q <= '0;
      bf_valid_q  <= 1'b0;
      bf_wreal_q  <= '0;
      bf_wimag_q  <= '0;
      bf_top_q    <= '0;
      bf_bot_q    <= '0;
      bf_stage_q  <= '0;
      bf_last_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      bfly_q      <= bfly_d;
      rom_en_q    <= rom_en_d;
      rom_index_q <= rom_index_d;
      bf_valid_q  <= bf_valid_d;
      bf_wreal_q  <= bf_wreal_d;
      bf_wimag_q  <= bf_wimag_d;
      bf_top_q    <= bf_top_d;
      bf_bot_q    <= bf_bot_d;
      bf_stage_q  <= bf_stage_d;
      bf_last_q   <= bf_last_d;
      done_q      <= done_d;
    end
  end

  assign rom_en    = rom_en_q;
  assign rom_index = rom_index_q;
  assign bf_valid  = bf_valid_q;
  assign bf_wreal  = bf_wreal_q;
  assign bf_wimag  = bf_wimag_q;
  assign bf_top    = bf_top_q;
  assign bf_bot    = bf_bot_q;
  assign bf_stage  = bf_stage_q;
  assign bf_last   = bf_last_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);

endmodule
